// File: rtl/classify_pkg.sv
// Shared types and constants for the digit classifier front-end.
// Includes the state encoding, the 7-segment codes and the built-in 12x12 digit bitmaps.
package classify_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_PREDICT = 2'd2
   } state_t;

   // Segment order {g,f,e,d,c,b,a}, active-low
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_E    = 7'b0000110;
   localparam logic [6:0] SEG_D0   = 7'b1000000;
   localparam logic [6:0] SEG_D1   = 7'b1111001;
   localparam logic [6:0] SEG_D2   = 7'b0100100;
   localparam logic [6:0] SEG_D3   = 7'b0110000;
   localparam logic [6:0] SEG_D4   = 7'b0011001;
   localparam logic [6:0] SEG_D5   = 7'b0010010;
   localparam logic [6:0] SEG_D6   = 7'b0000010;
   localparam logic [6:0] SEG_D7   = 7'b1111000;
   localparam logic [6:0] SEG_D8   = 7'b0000000;
   localparam logic [6:0] SEG_D9   = 7'b0010000;

   // Row-major, top row in the MSBs
   localparam logic [143:0] PAT_DIGIT5 = {
      12'b000000000000,
      12'b001111111100,
      12'b001000000000,
      12'b001000000000,
      12'b001111111000,
      12'b000000000100,
      12'b000000000100,
      12'b000000000100,
      12'b001000000100,
      12'b000111111000,
      12'b000000000000,
      12'b000000000000
   };

   localparam logic [143:0] PAT_DIGIT0 = {
      12'b000000000000,
      12'b000011110000,
      12'b000100001000,
      12'b001000000100,
      12'b001000000100,
      12'b001000000100,
      12'b001000000100,
      12'b001000000100,
      12'b001000000100,
      12'b000100001000,
      12'b000011110000,
      12'b000000000000
   };

   localparam logic [143:0] PAT_DIGIT4 = {
      12'b000000000000,
      12'b000000110000,
      12'b000001010000,
      12'b000010010000,
      12'b000100010000,
      12'b001000010000,
      12'b001111111100,
      12'b000000010000,
      12'b000000010000,
      12'b000000010000,
      12'b000000000000,
      12'b000000000000
   };

   localparam logic [143:0] PAT_DIGIT1 = {
      12'b000000000000,
      12'b000001100000,
      12'b000011100000,
      12'b000000100000,
      12'b000000100000,
      12'b000000100000,
      12'b000000100000,
      12'b000000100000,
      12'b000000100000,
      12'b000000100000,
      12'b000011111000,
      12'b000000000000
   };

   function automatic logic [6:0] digit_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_D0;
         4'd1:    s = SEG_D1;
         4'd2:    s = SEG_D2;
         4'd3:    s = SEG_D3;
         4'd4:    s = SEG_D4;
         4'd5:    s = SEG_D5;
         4'd6:    s = SEG_D6;
         4'd7:    s = SEG_D7;
         4'd8:    s = SEG_D8;
         4'd9:    s = SEG_D9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational display decode: error beats "no result", which beats the digit.
// Classes outside 0-9 show a dash.
module seg7_decoder
   import classify_pkg::*;
#(
   parameter int CLS_W = 4
) (
   input  logic [CLS_W-1:0] i_result,
   input  logic             i_result_valid,
   input  logic             i_error,
   output logic [6:0]       o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      if (i_error) begin
         o_seg = SEG_E;
      end else if (i_result_valid && (int'(i_result) <= 9)) begin
         o_seg = digit_seg(4'(i_result));
      end
   end

endmodule

// File: rtl/digit_classify_ctrl.sv
// Assembles a binary feature image from ROM or a pixel stream, runs the classifier
// with a predict/valid handshake and a timeout, and holds the last class for display.
module digit_classify_ctrl
   import classify_pkg::*;
#(
   parameter  int IMG_W   = 12,
   parameter  int IMG_H   = 12,
   parameter  int CLS_W   = 4,
   parameter  int N_PAT   = 4,
   parameter  int TIMEOUT = 255,
   localparam int N       = IMG_W * IMG_H,
   localparam int PW      = (N_PAT > 1) ? $clog2(N_PAT) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_mode,
   input  logic [PW-1:0]    i_pat_sel,
   input  logic             i_start,
   input  logic             i_pix_valid,
   input  logic             i_pix_data,
   output logic             o_pix_ready,
   output logic [N-1:0]     o_feature,
   output logic             o_predict,
   input  logic             i_cls_valid,
   input  logic [CLS_W-1:0] i_cls_result,
   output logic [CLS_W-1:0] o_result,
   output logic             o_result_valid,
   output logic             o_error,
   output logic             o_busy,
   output logic [6:0]       o_seg
);

   localparam int CNT_W  = $clog2(N + 1);
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   // Bitmaps are 144 bits; other image sizes get them truncated or zero-extended
   localparam logic [N-1:0] ROM_0 = N'(PAT_DIGIT5);
   localparam logic [N-1:0] ROM_1 = N'(PAT_DIGIT0);
   localparam logic [N-1:0] ROM_2 = N'(PAT_DIGIT4);
   localparam logic [N-1:0] ROM_3 = N'(PAT_DIGIT1);

   state_t             r_state;
   logic [N-1:0]       r_feature;
   logic [CNT_W-1:0]   r_pix_cnt;
   logic [WAIT_W-1:0]  r_wait;
   logic [CLS_W-1:0]   r_result;
   logic               r_result_valid;
   logic               r_error;
   logic [N-1:0]       w_rom_data;

   function automatic logic [N-1:0] rom_lookup(input logic [PW-1:0] idx);
      logic [N-1:0] d;
      d = '0;
      if (int'(idx) < N_PAT) begin
         case (int'(idx))
            0:       d = ROM_0;
            1:       d = ROM_1;
            2:       d = ROM_2;
            3:       d = ROM_3;
            default: d = '0;
         endcase
      end
      return d;
   endfunction

   assign w_rom_data = rom_lookup(i_pat_sel);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= ST_IDLE;
         r_feature      <= '0;
         r_pix_cnt      <= '0;
         r_wait         <= '0;
         r_result       <= '0;
         r_result_valid <= 1'b0;
         r_error        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_result_valid <= 1'b0;
                  r_error        <= 1'b0;
                  r_wait         <= '0;
                  if (i_mode) begin
                     r_pix_cnt <= '0;
                     r_state   <= ST_LOAD;
                  end else begin
                     r_feature <= w_rom_data;
                     r_state   <= ST_PREDICT;
                  end
               end
            end
            ST_LOAD: begin
               if (i_pix_valid) begin
                  r_feature <= {r_feature[N-2:0], i_pix_data};
                  if (r_pix_cnt == CNT_W'(N - 1)) begin
                     r_wait  <= '0;
                     r_state <= ST_PREDICT;
                  end else begin
                     r_pix_cnt <= r_pix_cnt + CNT_W'(1);
                  end
               end
            end
            ST_PREDICT: begin
               // A valid in the last allowed cycle still wins over the timeout
               if (i_cls_valid) begin
                  r_result       <= i_cls_result;
                  r_result_valid <= 1'b1;
                  r_state        <= ST_IDLE;
               end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
                  r_error <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_wait <= r_wait + WAIT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_pix_ready    = (r_state == ST_LOAD);
   assign o_predict      = (r_state == ST_PREDICT);
   assign o_busy         = (r_state != ST_IDLE);
   assign o_feature      = r_feature;
   assign o_result       = r_result;
   assign o_result_valid = r_result_valid;
   assign o_error        = r_error;

   seg7_decoder #(
      .CLS_W(CLS_W)
   ) u_seg7 (
      .i_result      (r_result),
      .i_result_valid(r_result_valid),
      .i_error       (r_error),
      .o_seg         (o_seg)
   );

endmodule

// File: tb/tb_digit_classify_ctrl.sv
// Directed bench for digit_classify_ctrl: ROM and stream runs, timeout, busy start,
// mid-load reset and out-of-range class, with expected run outcomes kept in a queue.
module tb_digit_classify_ctrl;

   localparam int N    = 144;
   localparam int TOUT = 8;

   localparam logic [N-1:0] DIG4 = {
      12'b000000000000, 12'b000000110000, 12'b000001010000, 12'b000010010000,
      12'b000100010000, 12'b001000010000, 12'b001111111100, 12'b000000010000,
      12'b000000010000, 12'b000000010000, 12'b000000000000, 12'b000000000000
   };

   logic         clk = 1'b0;
   logic         reset_n;
   logic         i_mode;
   logic [1:0]   i_pat_sel;
   logic         i_start;
   logic         i_pix_valid;
   logic         i_pix_data;
   logic         o_pix_ready;
   logic [N-1:0] o_feature;
   logic         o_predict;
   logic         i_cls_valid;
   logic [3:0]   i_cls_result;
   logic [3:0]   o_result;
   logic         o_result_valid;
   logic         o_error;
   logic         o_busy;
   logic [6:0]   o_seg;

   always #5 clk = ~clk;

   digit_classify_ctrl #(
      .IMG_W(12), .IMG_H(12), .CLS_W(4), .N_PAT(4), .TIMEOUT(TOUT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_mode        (i_mode),
      .i_pat_sel     (i_pat_sel),
      .i_start       (i_start),
      .i_pix_valid   (i_pix_valid),
      .i_pix_data    (i_pix_data),
      .o_pix_ready   (o_pix_ready),
      .o_feature     (o_feature),
      .o_predict     (o_predict),
      .i_cls_valid   (i_cls_valid),
      .i_cls_result  (i_cls_result),
      .o_result      (o_result),
      .o_result_valid(o_result_valid),
      .o_error       (o_error),
      .o_busy        (o_busy),
      .o_seg         (o_seg)
   );

   typedef struct {
      logic [3:0] res;
      logic       rv;
      logic       err;
      logic [6:0] seg;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [6:0] exp_seg(input logic [3:0] v);
      case (v)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] res, input logic rv, input logic err, input logic [6:0] seg);
      exp_t e;
      e.res = res; e.rv = rv; e.err = err; e.seg = seg;
      sb.push_back(e);
   endtask

   task automatic check_sb(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_result"}, N'(o_result), N'(e.res));
         chk({tag, "_result_valid"}, N'(o_result_valid), N'(e.rv));
         chk({tag, "_error"}, N'(o_error), N'(e.err));
         chk({tag, "_seg"}, N'(o_seg), N'(e.seg));
         chk({tag, "_busy"}, N'(o_busy), N'(0));
         $display("run %s: result=%0d valid=%0b error=%0b seg=%b", tag, o_result, o_result_valid, o_error, o_seg);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_feature"}, o_feature, '0);
      chk({tag, "_predict"}, N'(o_predict), N'(0));
      chk({tag, "_pix_ready"}, N'(o_pix_ready), N'(0));
      chk({tag, "_result"}, N'(o_result), N'(0));
      chk({tag, "_result_valid"}, N'(o_result_valid), N'(0));
      chk({tag, "_error"}, N'(o_error), N'(0));
      chk({tag, "_busy"}, N'(o_busy), N'(0));
      chk({tag, "_seg"}, N'(o_seg), N'(7'b0111111));
   endtask

   // Classifier stub: answers with val in the respond_at-th predict cycle (0 = never)
   task automatic do_predict(input int respond_at, input logic [3:0] val, input bit poke,
                             output int hi, output int lead);
      int guard;
      guard = 0;
      hi    = 0;
      lead  = 0;
      while (!o_predict && guard < 1000) begin
         @(negedge clk);
         lead++;
         guard++;
      end
      i_start = 1'b0;
      while (o_predict && guard < 1000) begin
         hi++;
         i_cls_valid  = (hi == respond_at);
         i_cls_result = val;
         i_start      = poke && (hi == 2);
         @(negedge clk);
         guard++;
      end
      i_cls_valid = 1'b0;
      i_start     = 1'b0;
      if (guard >= 1000) begin
         checks++;
         errors++;
         $error("FAIL predict_guard observed=%0d cycles expected=<1000", guard);
      end
   endtask

   task automatic stream(input logic [N-1:0] img, input int npix, input bit gaps);
      i_mode  = 1'b1;
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
      chk("load_pix_ready", N'(o_pix_ready), N'(1));
      for (int i = 0; i < npix; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               i_pix_valid = 1'b0;
               @(negedge clk);
            end
         end
         i_pix_valid = 1'b1;
         i_pix_data  = img[N-1-i];
         @(negedge clk);
      end
      i_pix_valid = 1'b0;
   endtask

   initial begin
      logic [N-1:0] img;
      logic [3:0]   pc;
      int           hi;
      int           lead;

      reset_n      = 1'b0;
      i_mode       = 1'b0;
      i_pat_sel    = '0;
      i_start      = 1'b0;
      i_pix_valid  = 1'b0;
      i_pix_data   = 1'b0;
      i_cls_valid  = 1'b0;
      i_cls_result = '0;
      repeat (2) @(negedge clk);
      chk_reset("por");
      reset_n = 1'b1;
      @(negedge clk);

      // ROM pattern 2 (digit 4), classifier answers 4 in the 4th predict cycle
      push_exp(4'd4, 1'b1, 1'b0, 7'b0011001);
      i_mode = 1'b0; i_pat_sel = 2'd2; i_start = 1'b1;
      do_predict(4, 4'd4, 1'b0, hi, lead);
      chk("rom_latency", N'(lead), N'(1));
      chk("rom_predict_cycles", N'(hi), N'(4));
      chk("rom_feature", o_feature, DIG4);
      check_sb("rom");

      // Stream with random gaps, stub echoes popcount of the assembled image
      for (int i = 0; i < N; i++) img[i] = 1'($urandom_range(0, 1));
      pc = 4'($countones(img));
      push_exp(pc, 1'b1, 1'b0, exp_seg(pc));
      stream(img, N, 1'b1);
      chk("stream_predict_rise", N'(o_predict), N'(1));
      chk("stream_feature", o_feature, img);
      do_predict(3, 4'($countones(o_feature)), 1'b0, hi, lead);
      chk("stream_predict_cycles", N'(hi), N'(3));
      check_sb("stream");

      // Classifier never answers: timeout, previous class retained
      push_exp(pc, 1'b0, 1'b1, 7'b0000110);
      i_mode = 1'b0; i_pat_sel = 2'd0; i_start = 1'b1;
      do_predict(0, 4'd0, 1'b0, hi, lead);
      chk("timeout_predict_cycles", N'(hi), N'(TOUT));
      check_sb("timeout");

      // Answer in the final allowed cycle, start poked while busy
      push_exp(4'd7, 1'b1, 1'b0, 7'b1111000);
      i_mode = 1'b0; i_pat_sel = 2'd1; i_start = 1'b1;
      do_predict(TOUT, 4'd7, 1'b1, hi, lead);
      chk("lastcycle_predict_cycles", N'(hi), N'(TOUT));
      check_sb("lastcycle");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_second_run_busy", N'(o_busy), N'(0));
      end

      // Reset in the middle of a stream load, then a clean stream run
      for (int i = 0; i < N; i++) img[i] = 1'($urandom_range(0, 1));
      stream(img, 70, 1'b0);
      chk("midload_busy", N'(o_busy), N'(1));
      #2 reset_n = 1'b0;
      #1 chk_reset("midload_reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < N; i++) img[i] = 1'($urandom_range(0, 1));
      pc = 4'($countones(img));
      push_exp(pc, 1'b1, 1'b0, exp_seg(pc));
      stream(img, N, 1'b0);
      chk("restream_feature", o_feature, img);
      do_predict(1, 4'($countones(o_feature)), 1'b0, hi, lead);
      chk("restream_predict_cycles", N'(hi), N'(1));
      check_sb("restream");

      // Class 12 is valid but has no digit glyph
      push_exp(4'd12, 1'b1, 1'b0, 7'b0111111);
      i_mode = 1'b0; i_pat_sel = 2'd3; i_start = 1'b1;
      do_predict(2, 4'd12, 1'b0, hi, lead);
      chk("cls12_predict_cycles", N'(hi), N'(2));
      check_sb("cls12");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/digit_classify_ctrl.md
# digit_classify_ctrl

Front-end controller for the digit classifiers (MLP, decision-tree, random-forest models). It assembles a binary IMG_W×IMG_H feature image, either from an internal pattern ROM or from a serial pixel stream, and launches the attached classifier with a predict/valid handshake. It enforces a timeout, holds the last class, and drives an active-low 7-segment display. It replaces the fixed four-pattern, free-running-predict top with a parametrised, handshaked controller.

## Interface
- IMG_W, 12, image width in pixels
- IMG_H, 12, image height in pixels; N = IMG_W*IMG_H feature bits
- CLS_W, 4, class result width
- N_PAT, 4, number of ROM patterns (≥2); PW = $clog2(N_PAT)
- TIMEOUT, 255, max cycles spent waiting for cls_valid (≥1)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = ROM pattern, 1 = pixel stream; sampled with start
- pat_sel  in  PW  ROM pattern index; sampled with start
- start  in  1  begin a classification; honoured only in IDLE
- pix_valid  in  1  stream pixel valid
- pix_data  in  1  stream pixel; first pixel = feature[N-1] (row-major, MSB first)
- pix_ready  out  1  high only in LOAD
- feature  out  N  image to classifier; held stable outside LOAD
- predict  out  1  high throughout PREDICT state only
- cls_valid  in  1  classifier result valid
- cls_result  in  CLS_W  classifier class
- result  out  CLS_W  last accepted class
- result_valid  out  1  result holds a class from the last run
- error  out  1  last run timed out
- busy  out  1  state != IDLE
- seg  out  7  {g,f,e,d,c,b,a}, active-low

## Operation
- FSM states: IDLE, LOAD, PREDICT.
- IDLE, start=1:
  - Clear result_valid and error.
  - mode=0: feature <= ROM[pat_sel], next state PREDICT. pat_sel ≥ N_PAT loads all-zero.
  - mode=1: pixel count <= 0, next state LOAD.
- LOAD:
  - pix_ready=1.
  - Each beat with pix_valid=1 shifts: feature <= {feature[N-2:0], pix_data}; count increments.
  - On the N-th beat, go to PREDICT. There is no abort; the only escape is reset.
- PREDICT:
  - predict=1; wait counter starts at 0 on entry.
  - cls_valid=1: result <= cls_result, result_valid <= 1, go to IDLE.
  - Else on the TIMEOUT-th PREDICT cycle: error <= 1, result unchanged, go to IDLE.
  - cls_valid in the final timeout cycle counts as success.
  - cls_valid outside PREDICT is ignored.
- start while busy is ignored (not queued).
- seg priority:
  - error → 7'b0000110 ('E').
  - else !result_valid → 7'b0111111 (dash).
  - else result 0–9 → standard digit codes (0 = 7'b1000000, 1 = 7'b1111001, …, 9 = 7'b0010000).
  - else result >9 → dash.
- ROM contents default to digits 5, 0, 4, 1 for indices 0–3; remaining indices are zero.

## Timing
- Reset (asynchronous):
  - State goes to IDLE.
  - feature=0, predict=0, pix_ready=0, result=0, result_valid=0, error=0, busy=0, seg=7'b0111111.
  - Reset mid-LOAD or mid-PREDICT discards the run.
- ROM mode:
  - start at edge t → predict high from cycle t+1.
  - If cls_valid is first seen at edge t+1+k, result_valid rises at t+2+k and predict falls in the same cycle.
- Stream mode: predict rises the cycle after the N-th accepted pixel; idle pix_valid cycles stall LOAD indefinitely.
- Timeout: predict is high for exactly TIMEOUT cycles, then error=1 and busy=0 on the next cycle.
- feature is registered; it is stable during the whole of PREDICT.
- Outputs are registered except seg (combinational from result/result_valid/error), busy, pix_ready and predict (decoded from state).

## Structure
- Package classify_pkg:
  - state enum.
  - SEG_DASH / SEG_E / digit segment constants.
  - Default ROM pattern constants (144-bit digits 5, 0, 4, 1).
- Sub-module seg7_decoder (result, result_valid, error → seg), purely combinational.
- ROM implemented as a parameter-indexed case inside the main block.

## Test plan
- Reset, then ROM mode with pat_sel=2; classifier stub returns 4 after 3 cycles → predict high 4 cycles, result=4, result_valid=1, seg=7'b0011001.
- Stream 144 pixels with random pix_valid gaps; stub echoes popcount[3:0] → feature equals the shifted pattern with the first bit at feature[143], and the result matches.
- Stub never asserts cls_valid, TIMEOUT=8 → predict high exactly 8 cycles, error=1, seg=7'b0000110, result keeps its previous value.
- cls_valid in the 8th cycle with TIMEOUT=8 → success, error=0; start pulsed while busy → ignored, no second run.
- reset_n asserted after 70 LOAD pixels → all outputs at reset values immediately; a new stream run completes correctly.
- cls_result=12 → result_valid=1, seg=7'b0111111.
